mdu_iterative: RTL and testbench
================================

// Module: mdu_iterative
// PURPOSE
// - Multi-cycle multiply/divide responder for the EXE stage. It accepts a MULT/MULTU/DIV/DIVU
//   request, runs a radix-2 iterative datapath and returns the result in architectural HI/LO.
// - Takes over from the single-cycle mul/div paths of the ALU. Hazard logic stalls on busy.
//   HI/LO are read by MFHI/MFLO.
// PARAMETERS
// - WIDTH  32  operand width; product HI:LO is 2*WIDTH; iteration count = WIDTH
// PORTS
// - clk          in   1      rising-edge clock
// - rst_n        in   1      asynchronous active-low reset
// - start        in   1      request strobe, sampled only in IDLE
// - op           in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
// - Op1          in   WIDTH  multiplicand / dividend (rs)
// - Op2          in   WIDTH  multiplier / divisor (rt)
// - flush        in   1      synchronous abort from pipeline flush
// - busy         out  1      high while a request is in flight
// - done         out  1      one-cycle pulse; HI/LO are valid in that cycle
// - div_by_zero  out  1      registered with done; 1 if a DIV/DIVU had Op2==0
// - HI           out  WIDTH  product[2W-1:W] or remainder
// - LO           out  WIDTH  product[W-1:0] or quotient
// BEHAVIOUR
// - Reset:
//   - State = IDLE; HI = 0, LO = 0; busy = 0, done = 0, div_by_zero = 0.
//   - Reset is asynchronous, so asserting it mid-operation kills the request with no done pulse.
// - States: IDLE -> CALC -> FIXUP -> IDLE.
// - Start edge E0: with start=1 in IDLE, the block latches op and the operand magnitudes plus
//   the result-sign flags, sets cnt=0, busy=1 and enters CALC.
// - CALC runs one iteration per edge for WIDTH edges:
//   - Multiply: shift-add on unsigned magnitudes.
//   - Divide: restoring shift-subtract on unsigned magnitudes.
//   - cnt==WIDTH-1 -> FIXUP.
// - FIXUP (edge E0+WIDTH+1):
//   - Applies sign correction, then writes HI/LO and div_by_zero.
//   - Sets done=1 and busy=0 for exactly one cycle, then returns to IDLE.
// - Latency: start edge to done cycle = WIDTH+1 edges (33 at default).
// - A new start is accepted in the same cycle that done is high.
// - Signed multiply: {HI,LO} = the full 2W-bit two's-complement product.
// - Unsigned multiply: {HI,LO} = the zero-extended product.
// - Signed divide:
//   - LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
//   - -2^(W-1) / -1 gives LO = 0x80000000, HI = 0, no flag.
// - Divide by zero: HI = Op1, LO = all ones, div_by_zero = 1, same latency.
// - start while busy is ignored; no queueing. The requester must hold until busy=0.
// - flush:
//   - At any state, the next edge returns the block to IDLE with busy=0 and no done.
//   - HI/LO keep their previous values.
//   - If flush and start are both high in IDLE, flush wins and the request is dropped.
// - HI/LO change only in the done cycle; they are stable at all other times.
// CONFIGURATION
// - MDU_EARLY_OUT_EN defined:
//   - A divide with Op2==0, or a multiply with Op1==0 or Op2==0, skips CALC.
//   - Result is written and done pulses at edge E0+1, with the same values as above.
// - MDU_EARLY_OUT_EN undefined: every request takes the full WIDTH+1 edges.
// TESTING
// - MULT Op1=0xFFFFFFFE, Op2=3 -> done at edge E0+33, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
// - MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, div_by_zero=0.
// - DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
// - DIVU 7/2 -> LO=3, HI=1.
// - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
// - DIVU 5/0 -> HI=5, LO=0xFFFFFFFF, div_by_zero=1.
//   - Done at E0+33, or at E0+1 with MDU_EARLY_OUT_EN.
// - Control: second start at E0+5 is ignored, and the first result is unchanged.
//   - flush at E0+10 -> busy=0, no done, HI/LO hold the prior result.
//   - rst_n low at E0+20 -> all outputs 0 immediately.

Source files
------------

// File: rtl/mdu_iterative.sv
// Radix-2 iterative multiply/divide unit returning results in HI/LO (IDLE -> CALC -> FIXUP).
// Optional MDU_EARLY_OUT_EN: zero-operand multiplies and divide-by-zero bypass CALC.
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] Op1,
  input  logic [WIDTH-1:0] Op2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, dz_out_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  // a_q: multiplicand/divisor magnitude; p_q: upper product/remainder; b_q: multiplier/quotient
  logic [WIDTH-1:0] a_q, p_q, b_q, p_d, b_d;
  logic             is_div_q, neg_lo_q, neg_hi_q, dz_q;

  logic             sgn_op, s1, s2, early, op2_zero;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   sum, shifted, diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] hi_fix, lo_fix;

  assign sgn_op   = ~op[0];
  assign s1       = sgn_op & Op1[WIDTH-1];
  assign s2       = sgn_op & Op2[WIDTH-1];
  assign mag1     = s1 ? -Op1 : Op1;
  assign mag2     = s2 ? -Op2 : Op2;
  assign op2_zero = (Op2 == '0);

`ifdef MDU_EARLY_OUT_EN
  assign early = op[1] ? op2_zero : ((Op1 == '0) || op2_zero);
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = early ? FIXUP : CALC;
      CALC:    if (cnt_q == LAST) state_d = FIXUP;
      FIXUP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    sum     = {1'b0, p_q} + {1'b0, a_q};
    shifted = {p_q, b_q[WIDTH-1]};
    diff    = shifted - {1'b0, a_q};
    p_d     = p_q;
    b_d     = b_q;
    if (is_div_q) begin
      if (!diff[WIDTH]) begin
        p_d = diff[WIDTH-1:0];
        b_d = {b_q[WIDTH-2:0], 1'b1};
      end else begin
        p_d = shifted[WIDTH-1:0];
        b_d = {b_q[WIDTH-2:0], 1'b0};
      end
    end else if (b_q[0]) begin
      {p_d, b_d} = {sum, b_q[WIDTH-1:1]};
    end else begin
      {p_d, b_d} = {1'b0, p_q, b_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_lo_q ? -{p_q, b_q} : {p_q, b_q};
    if (is_div_q) begin
      hi_fix = neg_hi_q ? -p_q : p_q;
      lo_fix = dz_q ? '1 : (neg_lo_q ? -b_q : b_q);
    end else begin
      hi_fix = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix = prod_fix[WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; datapath registers are reset
  // too so outputs read as zero straight after an asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      a_q      <= '0;
      p_q      <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        busy_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            is_div_q <= op[1];
            a_q      <= mag2;
            neg_lo_q <= s1 ^ s2;
            neg_hi_q <= op[1] ? s1 : (s1 ^ s2);
            dz_q     <= op[1] & op2_zero;
            p_q      <= '0;
            b_q      <= mag1;
            // Bypassed requests preload the values the full iteration would converge to.
            if (early) begin
              p_q <= op[1] ? mag1 : '0;
              b_q <= op[1] ? '1 : '0;
            end
          end
          CALC: begin
            cnt_q <= cnt_q + 1'b1;
            p_q   <= p_d;
            b_q   <= b_d;
          end
          FIXUP: begin
            hi_q     <= hi_fix;
            lo_q     <= lo_fix;
            dz_out_q <= dz_q;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dz_out_q;
  assign HI          = hi_q;
  assign LO          = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: stimulus pushes expected HI/LO/flag, a monitor pops on done.
module tb_mdu_iterative;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] Op1 = '0;
  logic [W-1:0] Op2 = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] HI, LO;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  mdu_iterative #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .Op1(Op1), .Op2(Op2),
    .flush(flush), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      check("done_has_expect", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("HI", 64'(HI), 64'(mon_e.hi));
        check("LO", 64'(LO), 64'(mon_e.lo));
        check("div_by_zero", 64'(div_by_zero), 64'(mon_e.dz));
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MDU_EARLY_OUT_EN
    if (o[1] ? (b == '0) : ((a == '0) || (b == '0))) return 1;
`endif
    return W + 1;
  endfunction

  task automatic start_req(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    op = o; Op1 = a; Op2 = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after the start edge until done is seen; lat is measured from E0.
  task automatic wait_done(input string name, input int lat, input int already);
    int  n = already;
    bit  seen = 1'b0;
    while (n < already + 100 && !seen) begin
      @(posedge clk);
      n++;
      #1 seen = done;
    end
    check({name, "_done_seen"}, 64'(seen), 64'd1);
    check({name, "_latency"}, 64'(n), 64'(lat));
    if (!seen) sb.delete();
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] hi, input logic [W-1:0] lo,
                     input logic dz);
    sb.push_back(exp_t'{hi, lo, dz});
    start_req(o, a, b);
    check({name, "_busy"}, 64'(busy), 64'd1);
    wait_done(name, exp_lat(o, a, b), 0);
    last_hi = hi;
    last_lo = lo;
  endtask

  initial begin
    #1;
    check("rst_flags", 64'({busy, done, div_by_zero}), 64'd0);
    check("rst_HI", 64'(HI), 64'd0);
    check("rst_LO", 64'(LO), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Back-to-back runs: each new start lands in the previous done cycle.
    run("mult_neg",  MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run("div_neg",   DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run("divu",      DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         1'b0);
    run("div_ovf",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
    run("divu_zero", DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1);
    run("mult_mix",  MULT,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run("div_negd",  DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);
    run("div_zero",  DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    run("mult_zero", MULT,  32'd0,         32'd12345,     32'd0,         32'd0,         1'b0);
    run("multu_hi",  MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         1'b0);
    run("divu_one",  DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0);

    // A second start while busy must be ignored.
    sb.push_back(exp_t'{32'd0, 32'h0003_0000, 1'b0});
    start_req(MULTU, 32'h0001_0000, 32'd3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    op = DIVU; Op1 = 32'd100; Op2 = 32'd0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("ignored_start", W + 1, 5);
    last_hi = 32'd0;
    last_lo = 32'h0003_0000;
    repeat (40) @(posedge clk);

    // Flush mid-operation: no done, HI/LO keep the prior result.
    start_req(DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_HI", 64'(HI), 64'(last_hi));
    check("flush_LO", 64'(LO), 64'(last_lo));
    repeat (40) @(posedge clk);
    #1;
    check("flush_HI_hold", 64'(HI), 64'(last_hi));
    check("flush_LO_hold", 64'(LO), 64'(last_lo));

    // Flush wins over start in IDLE.
    @(negedge clk);
    op = MULTU; Op1 = 32'd9; Op2 = 32'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    check("flush_start_busy", 64'(busy), 64'd0);
    repeat (40) @(posedge clk);

    // Asynchronous reset mid-operation kills the request.
    start_req(MULT, 32'd1234, 32'd5678);
    repeat (19) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("arst_flags", 64'({busy, done, div_by_zero}), 64'd0);
    check("arst_HI", 64'(HI), 64'd0);
    check("arst_LO", 64'(LO), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(posedge clk);

    run("after_rst", DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    repeat (5) @(posedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
